// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM -> WB retire bus with valid/ready handshake.
// master = MEM stage side, slave = write-back stage side.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_data;
    logic [2:0]        in_load_type;

    modport master (
        output in_valid,
        output in_rd,
        output in_reg_write,
        output in_mem_to_reg,
        output in_alu_result,
        output in_mem_data,
        output in_load_type,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rd,
        input  in_reg_write,
        input  in_mem_to_reg,
        input  in_alu_result,
        input  in_mem_data,
        input  in_load_type,
        output in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage, stage register + one-entry skid, load align.
// Define WB_RETIRE_COUNT_EN to add the retire_count output.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_stage_if.slave         in_if,
    input  logic              wb_stall,
    output logic [ADDR_W-1:0] addrssw,
    output logic              write,
    output logic [DATA_W-1:0] write_material,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]       retire_count,
`endif
    output logic              misalign
);

    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic              reg_write;
        logic              mis;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t stage_q;
    entry_t skid_q;
    logic   stage_v;
    logic   skid_v;

    entry_t     cap;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        accept;
    logic        head_ok;

    assign in_if.in_ready = !skid_v;
    assign accept = in_if.in_valid & !skid_v;

    assign byte_sel = in_if.in_mem_data[{in_if.in_alu_result[1:0], 3'b000} +: 8];
    assign half_sel = in_if.in_alu_result[1] ? in_if.in_mem_data[31:16]
                                             : in_if.in_mem_data[15:0];

    // Alignment and extension are resolved once, at capture time.
    always_comb begin
        cap           = '0;
        cap.rd        = in_if.in_rd;
        cap.reg_write = in_if.in_reg_write;
        cap.data      = in_if.in_alu_result;
        cap.mis       = 1'b0;
        if (in_if.in_mem_to_reg) begin
            case (in_if.in_load_type)
                LT_LH: begin
                    cap.data = {{(DATA_W-16){half_sel[15]}}, half_sel};
                    cap.mis  = in_if.in_alu_result[0];
                end
                LT_LHU: begin
                    cap.data = {{(DATA_W-16){1'b0}}, half_sel};
                    cap.mis  = in_if.in_alu_result[0];
                end
                LT_LB: begin
                    cap.data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
                end
                LT_LBU: begin
                    cap.data = {{(DATA_W-8){1'b0}}, byte_sel};
                end
                default: begin
                    cap.data = in_if.in_mem_data;
                    cap.mis  = |in_if.in_alu_result[1:0];
                end
            endcase
        end
    end

    // Skid only fills while the stage is held; it always drains first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_v <= 1'b0;
            skid_v  <= 1'b0;
            stage_q <= '0;
            skid_q  <= '0;
        end else begin
            if (!stage_v || !wb_stall) begin
                if (skid_v) begin
                    stage_q <= skid_q;
                    stage_v <= 1'b1;
                    skid_v  <= 1'b0;
                end else if (accept) begin
                    stage_q <= cap;
                    stage_v <= 1'b1;
                end else begin
                    stage_v <= 1'b0;
                end
            end else if (accept) begin
                skid_q <= cap;
                skid_v <= 1'b1;
            end
        end
    end

    assign head_ok = stage_v & stage_q.reg_write
                   & (|stage_q.rd) & !stage_q.mis;

    assign fwd_valid      = head_ok;
    assign write          = head_ok & !wb_stall;
    assign addrssw        = stage_v ? stage_q.rd : '0;
    assign write_material = stage_v ? stage_q.data : '0;
    assign fwd_rd         = addrssw;
    assign fwd_data       = write_material;
    assign misalign       = stage_v & stage_q.mis & !wb_stall;

`ifdef WB_RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (stage_v && !wb_stall) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, stall/skid and reset sequences, random vs model.
// Build with WB_RETIRE_COUNT_EN to also check retire_count.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_stall;
    logic [4:0]  addrssw;
    logic        write;
    logic [31:0] write_material;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        misalign;
    logic [31:0] rc;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stage_if bus();

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_count;
    assign rc = retire_count;
`else
    assign rc = 32'd0;
`endif

    wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_if          (bus),
        .wb_stall       (wb_stall),
        .addrssw        (addrssw),
        .write          (write),
        .write_material (write_material),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
`ifdef WB_RETIRE_COUNT_EN
        .retire_count   (retire_count),
`endif
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    logic [31:0] rf [32];
    always @(posedge clk) if (write) rf[addrssw] <= write_material;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_data(input logic m2r, input logic [2:0] lt,
                                             input logic [31:0] a, input logic [31:0] m);
        logic [31:0] b;
        logic [31:0] h;
        b = (m >> (8 * (a % 4))) & 32'hFF;
        h = (m >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (!m2r) return a;
        case (lt)
            3'd3:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return h;
            default: return m;
        endcase
    endfunction

    function automatic logic ref_mis(input logic m2r, input logic [2:0] lt,
                                     input logic [31:0] a);
        if (!m2r) return 1'b0;
        if (lt == 3'd1 || lt == 3'd2) return (a % 2) != 0;
        if (lt == 3'd3 || lt == 3'd4) return 1'b0;
        return (a % 4) != 0;
    endfunction

    typedef struct {
        logic [4:0]  rd;
        logic        m2r;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic        wr;
        logic [31:0] data;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic [31:0] data;
    } mdl_t;

    vec_t vt [10];
    mdl_t q[$];
    int   got[$];
    int   got_cyc[$];
    logic [31:0] exp_rc;

    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.in_rd         = '0;
        bus.in_reg_write  = 1'b0;
        bus.in_mem_to_reg = 1'b0;
        bus.in_alu_result = '0;
        bus.in_mem_data   = '0;
        bus.in_load_type  = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] v);
        bus.in_valid      = 1'b1;
        bus.in_rd         = rd;
        bus.in_reg_write  = 1'b1;
        bus.in_mem_to_reg = 1'b0;
        bus.in_alu_result = v;
        bus.in_load_type  = '0;
    endtask

    function automatic logic [127:0] all_out();
        return {write, addrssw, write_material, fwd_valid, fwd_rd,
                fwd_data, misalign, bus.in_ready, rc};
    endfunction

    initial begin
        logic [31:0] md;
        logic        ok;
        logic        acc;
        md = 32'h80FF_7F01;
        vt[0] = '{5'd5,  1'b0, 3'd0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
        vt[1] = '{5'd6,  1'b1, 3'd3, 32'h0000_0003, 1'b1, 32'hFFFF_FF80, 1'b0};
        vt[2] = '{5'd7,  1'b1, 3'd4, 32'h0000_0003, 1'b1, 32'h0000_0080, 1'b0};
        vt[3] = '{5'd8,  1'b1, 3'd1, 32'h0000_0002, 1'b1, 32'hFFFF_80FF, 1'b0};
        vt[4] = '{5'd9,  1'b1, 3'd2, 32'h0000_0000, 1'b1, 32'h0000_7F01, 1'b0};
        vt[5] = '{5'd0,  1'b0, 3'd0, 32'h0000_DEAD, 1'b0, 32'h0000_DEAD, 1'b0};
        vt[6] = '{5'd10, 1'b1, 3'd1, 32'h0000_0001, 1'b0, 32'h0,         1'b1};
        vt[7] = '{5'd11, 1'b1, 3'd0, 32'h0000_0022, 1'b0, 32'h0,         1'b1};
        vt[8] = '{5'd12, 1'b1, 3'd7, 32'h0000_0100, 1'b1, 32'h80FF_7F01, 1'b0};
        vt[9] = '{5'd13, 1'b1, 3'd3, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 1'b0};

        // Reset state
        rst_n    = 1'b0;
        wb_stall = 1'b0;
        drive_idle();
        #3;
        chk("reset_outputs", all_out(), {1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                                         32'd0, 1'b0, 1'b1, 32'd0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, one retirement each
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid      = 1'b1;
            bus.in_rd         = vt[i].rd;
            bus.in_reg_write  = 1'b1;
            bus.in_mem_to_reg = vt[i].m2r;
            bus.in_load_type  = vt[i].lt;
            bus.in_alu_result = vt[i].alu;
            bus.in_mem_data   = md;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d", i),
                {write, addrssw, vt[i].mis ? 32'd0 : write_material,
                 fwd_valid, misalign},
                {vt[i].wr, vt[i].rd, vt[i].mis ? 32'd0 : vt[i].data,
                 vt[i].wr, vt[i].mis});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_drain", i), {write, misalign, fwd_valid},
                3'b000);
            if (i == 0) chk("rf5", rf[5], 32'h1234_5678);
        end
`ifdef WB_RETIRE_COUNT_EN
        chk("retire10", rc, 32'd10);
`endif

        // Stall with three back-to-back inputs
        @(negedge clk);
        wb_stall = 1'b1;
        drive_alu(5'd1, 32'h101);
        @(posedge clk);
        #1;
        chk("stall_ready1", bus.in_ready, 1'b1);
        drive_alu(5'd2, 32'h202);
        @(posedge clk);
        #1;
        chk("stall_ready2", bus.in_ready, 1'b0);
        drive_alu(5'd3, 32'h303);
        chk("stall_hold", {write, fwd_valid, fwd_rd, fwd_data},
            {1'b0, 1'b1, 5'd1, 32'h101});
        @(posedge clk);
        #1;
        chk("stall_rc", rc, exp_rc_tbl());
        wb_stall = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (write) begin
                got.push_back(int'(addrssw));
                got_cyc.push_back(c);
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc && bus.in_rd == 5'd3) bus.in_valid = 1'b0;
        end
        chk("skid_count", got.size(), 3);
        ok = (got.size() == 3);
        for (int k = 0; k < got.size() && k < 3; k++)
            if (got[k] != k + 1 || got_cyc[k] != k) ok = 1'b0;
        chk("skid_order", ok, 1'b1);
        chk("rf_123", {rf[1], rf[2], rf[3]}, {32'h101, 32'h202, 32'h303});
`ifdef WB_RETIRE_COUNT_EN
        chk("retire13", rc, 32'd13);
`endif

        // Reset while stage and skid are full and stalled
        @(negedge clk);
        wb_stall = 1'b1;
        drive_alu(5'd4, 32'h444);
        @(posedge clk);
        #1;
        drive_alu(5'd6, 32'h666);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("full_before_reset", {bus.in_ready, fwd_valid}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_midstall", all_out(), {1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                                          32'd0, 1'b0, 1'b1, 32'd0});
        @(negedge clk);
        wb_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (write || fwd_valid) ok = 1'b0;
        end
        chk("reset_discard", ok, 1'b1);

        // Random traffic against a FIFO-level model
        exp_rc = rc;
        for (int c = 0; c < 3000; c++) begin
            mdl_t h;
            logic [127:0] e;
            @(negedge clk);
            bus.in_valid      = ($urandom_range(0, 9) < 6);
            bus.in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0
                                : 5'($urandom_range(1, 31));
            bus.in_reg_write  = ($urandom_range(0, 7) != 0);
            bus.in_mem_to_reg = $urandom_range(0, 1) == 1;
            bus.in_load_type  = 3'($urandom_range(0, 7));
            bus.in_alu_result = $urandom;
            bus.in_mem_data   = $urandom;
            wb_stall          = ($urandom_range(0, 9) < 3);
            #1;
            if (q.size() > 0) begin
                h = q[0];
                e = {h.rw && h.rd != 0 && !h.mis && !wb_stall, h.rd, h.data,
                     h.rw && h.rd != 0 && !h.mis, h.rd, h.data,
                     h.mis && !wb_stall, q.size() < 2, exp_rc};
            end else begin
                e = {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, exp_rc};
            end
            chk($sformatf("rand%0d", c), all_out(), e);
            @(posedge clk);
            acc = bus.in_valid && q.size() < 2;
            if (q.size() > 0 && !wb_stall) begin
                void'(q.pop_front());
`ifdef WB_RETIRE_COUNT_EN
                exp_rc = exp_rc + 32'd1;
`endif
            end
            if (acc) begin
                h.rd   = bus.in_rd;
                h.rw   = bus.in_reg_write;
                h.mis  = ref_mis(bus.in_mem_to_reg, bus.in_load_type,
                                 bus.in_alu_result);
                h.data = ref_data(bus.in_mem_to_reg, bus.in_load_type,
                                  bus.in_alu_result, bus.in_mem_data);
                q.push_back(h);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [31:0] exp_rc_tbl();
`ifdef WB_RETIRE_COUNT_EN
        return 32'd10;
`else
        return 32'd0;
`endif
    endfunction

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 32-bit MIPS pipeline and the write-side end of the register file interface. It accepts retired MEM-stage results over a valid/ready handshake, buffers them through a stage register plus a one-entry skid buffer, and applies load byte/halfword selection and extension. It then drives the register file write port (addrssw, write, write_material), and also supplies forwarding data to the ID/EX bypass logic.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  pipeline clock; the register file samples write on the same posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM stage presents a retiring instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rd  in  5  destination register.
- in_reg_write  in  1  instruction writes a register.
- in_mem_to_reg  in  1  1 = write load data, 0 = write ALU result.
- in_alu_result  in  32  ALU result; also the effective address for loads.
- in_mem_data  in  32  raw word read from data memory.
- in_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; any other code is treated as LW.
- wb_stall  in  1  hold: no write is performed and the stage does not advance.
- addrssw  out  5  register file write address.
- write  out  1  register file write enable.
- write_material  out  32  register file write data.
- fwd_valid  out  1  a pending write is visible for bypass.
- fwd_rd  out  5  bypass destination register.
- fwd_data  out  32  bypass data; equal to write_material.
- misalign  out  1  one-cycle pulse when a misaligned load is dropped.

Behaviour:
- Reset (async, rst_n=0): stage and skid both invalid. Outputs: write=0, addrssw=0, write_material=0, fwd_valid=0, fwd_rd=0, fwd_data=0, misalign=0, in_ready=1.
- Accept: a transfer occurs on a posedge where in_valid=1 and in_ready=1.
- in_ready = !skid_valid, a registered-state function with no combinational path from in_valid.
- Data processing at capture:
  - Byte lane = in_alu_result[1:0], little-endian.
  - LB / LBU: select the byte, then sign- or zero-extend it.
  - LH / LHU: select the half using addr[1], then extend it.
  - LW: pass the word through.
  - in_mem_to_reg=0: use in_alu_result and ignore the load type.
  - Final data is stored in the stage register; extension is not recomputed at output.
- Misalignment: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - The entry is captured with its write suppressed.
  - misalign pulses high for the single cycle the entry occupies the stage head with wb_stall=0.
- Write port, all combinational from the stage register:
  - write = stage_valid & reg_write & (rd!=0) & !misaligned & !wb_stall.
  - addrssw = rd; write_material = data.
  - When stage invalid: addrssw=0 and write_material=0.
- Latency: accept at edge N → write high during cycle N..N+1 → register file updated at edge N+1 (when not stalled).
- Forwarding: fwd_valid = stage_valid & reg_write & (rd!=0) & !misaligned. It is independent of wb_stall, so bypass still sees a held value.
- Advance rules:
  - Stage empties at a posedge where wb_stall=0.
  - Skid moves to the stage at that edge.
  - A new accept goes into the stage if the stage is empty or emptying; otherwise it goes into the skid.
- Simultaneous events:
  - Accept with stall=0: the stage refills at the same edge, giving back-to-back writes every cycle.
  - Accept while stalled with stage full: the entry goes to the skid and in_ready drops the next cycle.
  - Two accepts are never lost; ordering is strictly FIFO.
- Register 0: never written; fwd_valid stays 0 for rd=0.
- Reset mid-stall: the stage and skid contents are discarded immediately and no write is issued.

Optional Feature:
- WB_RETIRE_COUNT_EN: adds output retire_count [31:0].
  - Reset value 0.
  - Increments by 1 on each posedge where a stage entry leaves with wb_stall=0, including entries with no register write or a misaligned load.
  - Wraps from 0xFFFFFFFF to 0.
- Without the macro: the port and the counter logic are absent.

Test Plan:
- Reset: hold rst_n=0 mid-stream → all outputs 0 and in_ready=1 asynchronously, before the next clk edge.
- ALU write: rd=5, alu=0x1234_5678, mem_to_reg=0 → next cycle write=1, addrssw=5, write_material=0x12345678; register 5 reads 0x12345678 after that edge.
- Byte and halfword loads with mem_data=0x80FF_7F01:
  - LB, addr=0x3 → 0xFFFFFF80
  - LBU, addr=0x3 → 0x00000080
  - LH, addr=0x2 → 0xFFFF80FF
  - LHU, addr=0x0 → 0x00007F01
- rd=0 and misalignment:
  - rd=0, alu=0xDEAD → write=0 and fwd_valid=0.
  - LH with addr=0x1 → write=0 and misalign=1 for one cycle.
- Stall/skid: stall=1 with 3 back-to-back valid inputs (rd=1, 2, 3) → in_ready drops after the second accept; after releasing stall, writes occur in order 1, 2, 3 on consecutive cycles with no loss or duplication.
- WB_RETIRE_COUNT_EN: retire 10 entries, including 2 misaligned ones and 1 with rd=0 → retire_count=10; stalled cycles do not increment it.
